// File: rtl/pc_pkg.sv
// Shared types and helpers for the next-PC unit: select encoding, instruction
// size and the J-type target concatenation.
`timescale 1ns/1ps
package pc_pkg;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_RET
    } next_sel_t;

    localparam int INSTR_BYTES = 4;
    localparam int MAX_WIDTH   = 64;

    // {upper[3:0], index, 2'b00} placed in a width-bit field; index must be zero above width-6.
    function automatic logic [MAX_WIDTH-1:0] jump_target(
        input logic [3:0]           upper,
        input logic [MAX_WIDTH-1:0] index,
        input int                   width
    );
        return (MAX_WIDTH'(upper) << (width - 4)) | (index << 2);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push, pop and replace-top, with count,
// empty/full flags and a registered overflow pulse when the oldest entry is lost.
`timescale 1ns/1ps
module pc_ras #(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             overflow
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

    logic [WIDTH-1:0] stack_mem [RAS_DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    top_idx;
    logic [CW-1:0]    count;
    logic             overflow_q;
    logic             do_push;
    logic             do_replace;
    logic             do_pop;

    // ptr addresses the next free slot; when full it also addresses the oldest entry.
    assign top_idx  = ptr - PW'(1);
    assign top      = stack_mem[top_idx];
    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign overflow = overflow_q;

    // A simultaneous push and pop replaces the top, or acts as a plain push when empty.
    assign do_push    = en & push & (~pop | empty);
    assign do_replace = en & push & pop & ~empty;
    assign do_pop     = en & pop & ~push & ~empty;

    // NOTE: storage has no reset; count and ptr alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[ptr] <= push_data;
        end else if (do_replace) begin
            stack_mem[top_idx] <= push_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= 1'b0;
            if (do_push) begin
                ptr <= ptr + PW'(1);
                if (full) begin
                    overflow_q <= 1'b1;
                end else begin
                    count <= count + CW'(1);
                end
            end else if (do_pop) begin
                ptr   <= ptr - PW'(1);
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC stage: registered PC, ret > jump > branch > sequential selection,
// stall hold and return-address stack. Optional misaligned-target trap: PC_ALIGN_TRAP_EN.
`timescale 1ns/1ps
module pc_next_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(32'h0000_0000),
    parameter int               RAS_DEPTH   = 4,
    parameter logic [WIDTH-1:0] TRAP_VECTOR = WIDTH'(32'h0000_0080)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump,
    input  logic [WIDTH-7:0] jump_index,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] ret_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pcplus4,
    output logic [WIDTH-1:0] pcbranch,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             misalign
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] ras_top;
    logic [WIDTH-1:0] jtarget;
    logic [WIDTH-1:0] rtarget;
    logic [WIDTH-1:0] sel_pc;
    logic [WIDTH-1:0] aligned_pc;
    logic [WIDTH-1:0] next_pc;
    logic             trap;
    next_sel_t        sel;

    assign pc       = pc_q;
    assign pcplus4  = pc_q + WIDTH'(INSTR_BYTES);
    assign pcbranch = pcplus4 + (branch_offset << 2);
    assign jtarget  = WIDTH'(jump_target(pcplus4[WIDTH-1:WIDTH-4], MAX_WIDTH'(jump_index), WIDTH));
    assign rtarget  = ras_empty ? ret_target : ras_top;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        sel = SEL_SEQ;
        if (ret) begin
            sel = SEL_RET;
        end else if (jump) begin
            sel = SEL_JUMP;
        end else if (branch_taken) begin
            sel = SEL_BRANCH;
        end
    end

    always_comb begin
        sel_pc = pcplus4;
        case (sel)
            SEL_RET:    sel_pc = rtarget;
            SEL_JUMP:   sel_pc = jtarget;
            SEL_BRANCH: sel_pc = pcbranch;
            default:    sel_pc = pcplus4;
        endcase
    end

`ifdef PC_ALIGN_TRAP_EN
    logic misalign_q;

    assign trap       = |sel_pc[1:0];
    assign aligned_pc = sel_pc;
    assign misalign   = misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= ~stall & trap;
        end
    end
`else
    assign trap       = 1'b0;
    assign aligned_pc = sel_pc & ~WIDTH'(3);
    assign misalign   = 1'b0;
`endif

    assign next_pc = trap ? TRAP_VECTOR : aligned_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (!stall) begin
            pc_q <= next_pc;
        end
    end

    // The stack sees the same stall as the PC so both hold together.
    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (~stall),
        .push      (jump & call),
        .pop       (ret),
        .push_data (pcplus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_overflow)
    );

endmodule
